ws2812_frame_ctrl: RTL

//   Sequences the WS2812 receive datapath: consumes decoded bits (decode_bit/shift_en) and the

---
 rtl/ws2812_frame_ctrl_pkg.sv | 26 ++
 rtl/ws2812_frame_ctrl_pixel_assembler.sv | 49 ++++
 rtl/ws2812_frame_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ws2812_frame_ctrl_pkg.sv
// Shared types and constants for the WS2812 receive frame controller.
// Holds the decoder-to-controller bundle, the controller FSM encoding and the pixel record.
package ws2812_frame_ctrl_pkg;

  localparam int BITS_PER_PIXEL = 24;

  typedef struct packed {
    logic decode_bit;
    logic shift_en;
    logic treset;
  } shift_reg_input_t;

  typedef enum logic [1:0] {
    SYNC,
    CAPTURE,
    FORWARD,
    LATCH
  } frame_ctrl_state_e;

  typedef struct packed {
    logic                      valid;
    logic [BITS_PER_PIXEL-1:0] data;
    logic [7:0]                addr;
  } pixel_out_t;

endpackage

// File: rtl/ws2812_frame_ctrl_pixel_assembler.sv
// MSB-first shift accumulator with bit counter; done_o/word_o are combinational on the completing bit.
// Zero latency to done_o, no backpressure; clear_i wins over a simultaneous shift for the stored state.
module ws2812_frame_ctrl_pixel_assembler #(
  parameter int BITS = 24
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            shift_i,
  input  logic            bit_i,
  input  logic            clear_i,
  output logic            done_o,
  output logic [BITS-1:0] word_o,
  output logic            partial_o
);

  localparam int BW = $clog2(BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(BITS - 1);

  logic [BITS-1:0] acc_q, acc_d;
  logic [BW-1:0]   cnt_q, cnt_d;

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (shift_i) begin
      acc_d = {acc_q[BITS-2:0], bit_i};
      cnt_d = (cnt_q == LAST_BIT) ? '0 : cnt_q + BW'(1);
    end
  end

  // Outputs reflect the bit being shifted this cycle so the caller sees the completed word.
  assign done_o    = shift_i && (cnt_q == LAST_BIT);
  assign word_o    = acc_d;
  assign partial_o = (cnt_d != '0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ws2812_frame_ctrl.sv
// Frames decoded WS2812 bits into pixels, claims the first NUM_PIXELS, then forwards the rest.
// Pixel and frame-done outputs are registered, 1 cycle after the causing input; no backpressure.
module ws2812_frame_ctrl
  import ws2812_frame_ctrl_pkg::*;
#(
  parameter int NUM_PIXELS   = 8,
  parameter int BITS_PER_PIX = BITS_PER_PIXEL,
  localparam int AW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1,
  localparam int CW = $clog2(NUM_PIXELS + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  shift_reg_input_t        i_shift_reg,
  output logic                    o_pixel_valid,
  output logic [BITS_PER_PIX-1:0] o_pixel_data,
  output logic [AW-1:0]           o_pixel_addr,
  output logic                    o_fwd_en,
  output logic                    o_frame_done,
  output logic [CW-1:0]           o_pixel_count,
  output logic                    o_err_partial
);

  localparam logic [CW-1:0] LAST_PIX = CW'(NUM_PIXELS - 1);
  localparam logic [CW-1:0] MAX_PIX  = CW'(NUM_PIXELS);

  frame_ctrl_state_e state_q, state_d;

  logic                    treset_d_q;
  logic                    treset_rise;
  logic                    latch_req;
  logic [CW-1:0]           pix_cnt_q, pix_cnt_d, pix_cnt_inc;
  logic                    got_bits_q, got_bits_d;

  logic                    asm_shift;
  logic                    asm_clear;
  logic                    asm_done;
  logic                    asm_partial;
  logic [BITS_PER_PIX-1:0] asm_word;

  logic                    pix_vld_q, pix_vld_d;
  logic [BITS_PER_PIX-1:0] pix_dat_q, pix_dat_d;
  logic [AW-1:0]           pix_addr_q, pix_addr_d;
  logic                    fwd_en_q, fwd_en_d;
  logic                    frame_done_q, frame_done_d;
  logic [CW-1:0]           pix_count_q, pix_count_d;
  logic                    err_partial_q, err_partial_d;

  assign treset_rise = i_shift_reg.treset & ~treset_d_q;
  assign asm_shift   = i_shift_reg.shift_en && (state_q == CAPTURE);
  assign pix_cnt_inc = (pix_cnt_q == MAX_PIX) ? pix_cnt_q : pix_cnt_q + CW'(1);
  // A bit arriving together with the gap edge still makes the frame non-empty.
  assign latch_req   = treset_rise && (got_bits_q || i_shift_reg.shift_en);

  ws2812_frame_ctrl_pixel_assembler #(
    .BITS (BITS_PER_PIX)
  ) u_assembler (
    .clk_i     (i_clk),
    .rst_n_i   (i_reset_n),
    .shift_i   (asm_shift),
    .bit_i     (i_shift_reg.decode_bit),
    .clear_i   (asm_clear),
    .done_o    (asm_done),
    .word_o    (asm_word),
    .partial_o (asm_partial)
  );

  always_comb begin
    state_d       = state_q;
    pix_cnt_d     = pix_cnt_q;
    got_bits_d    = got_bits_q;
    asm_clear     = 1'b0;
    pix_vld_d     = 1'b0;
    pix_dat_d     = pix_dat_q;
    pix_addr_d    = pix_addr_q;
    frame_done_d  = 1'b0;
    pix_count_d   = pix_count_q;
    err_partial_d = 1'b0;

    case (state_q)
      SYNC: begin
        if (i_shift_reg.treset) begin
          state_d    = CAPTURE;
          asm_clear  = 1'b1;
          pix_cnt_d  = '0;
          got_bits_d = 1'b0;
        end
      end

      CAPTURE: begin
        if (i_shift_reg.shift_en) begin
          got_bits_d = 1'b1;
        end
        if (asm_done) begin
          pix_vld_d  = 1'b1;
          pix_dat_d  = asm_word;
          pix_addr_d = pix_cnt_q[AW-1:0];
          pix_cnt_d  = pix_cnt_inc;
        end
        // The completing bit is processed first, so its pixel is included in the count.
        if (latch_req) begin
          state_d       = LATCH;
          frame_done_d  = 1'b1;
          pix_count_d   = asm_done ? pix_cnt_inc : pix_cnt_q;
          err_partial_d = asm_partial;
          asm_clear     = 1'b1;
          pix_cnt_d     = '0;
          got_bits_d    = 1'b0;
        end else if (asm_done && (pix_cnt_q == LAST_PIX)) begin
          state_d = FORWARD;
        end
      end

      FORWARD: begin
        if (latch_req) begin
          state_d      = LATCH;
          frame_done_d = 1'b1;
          pix_count_d  = pix_cnt_q;
          asm_clear    = 1'b1;
          pix_cnt_d    = '0;
          got_bits_d   = 1'b0;
        end
      end

      LATCH: begin
        state_d   = CAPTURE;
        asm_clear = 1'b1;
      end

      default: begin
        state_d = SYNC;
      end
    endcase

    fwd_en_d = (state_d == FORWARD);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= SYNC;
      treset_d_q    <= 1'b0;
      pix_cnt_q     <= '0;
      got_bits_q    <= 1'b0;
      pix_vld_q     <= 1'b0;
      pix_dat_q     <= '0;
      pix_addr_q    <= '0;
      fwd_en_q      <= 1'b0;
      frame_done_q  <= 1'b0;
      pix_count_q   <= '0;
      err_partial_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      treset_d_q    <= i_shift_reg.treset;
      pix_cnt_q     <= pix_cnt_d;
      got_bits_q    <= got_bits_d;
      pix_vld_q     <= pix_vld_d;
      pix_dat_q     <= pix_dat_d;
      pix_addr_q    <= pix_addr_d;
      fwd_en_q      <= fwd_en_d;
      frame_done_q  <= frame_done_d;
      pix_count_q   <= pix_count_d;
      err_partial_q <= err_partial_d;
    end
  end

  assign o_pixel_valid = pix_vld_q;
  assign o_pixel_data  = pix_dat_q;
  assign o_pixel_addr  = pix_addr_q;
  assign o_fwd_en      = fwd_en_q;
  assign o_frame_done  = frame_done_q;
  assign o_pixel_count = pix_count_q;
  assign o_err_partial = err_partial_q;

endmodule
